// File: rtl/wgt_load_ctrl_pkg.sv
// Shared types and constants for the PE-row weight-load controller.
package wgt_load_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Weight slots per PE; the PE array sizes its slot storage from the same value.
  localparam int WGT_DEPTH    = 2;
  localparam int DEF_ID_WIDTH = 6;

  // $clog2 that never returns 0, so a counter for a 1-deep range still has a bit.
  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/wgt_load_ctrl_if.sv
// Weight stream, load bus, pop and status signals between the weight buffer
// side (master) and the load controller (slave).
interface wgt_load_ctrl_if #(
  parameter int ID_WIDTH   = wgt_load_ctrl_pkg::DEF_ID_WIDTH,
  parameter int DATA_WIDTH = 8
);

  logic                  i_start;
  logic                  i_wgt_vld;
  logic [DATA_WIDTH-1:0] i_wgt_data;
  logic                  o_wgt_rdy;
  logic                  o_load_vld;
  logic [ID_WIDTH-1:0]   o_load_id;
  logic [DATA_WIDTH-1:0] o_load_data;
  logic                  i_pop_req;
  logic                  o_pop_vld;
  logic                  o_busy;
  logic                  o_done;
  logic                  o_loaded;

  modport master (
    output i_start, i_wgt_vld, i_wgt_data, i_pop_req,
    input  o_wgt_rdy, o_load_vld, o_load_id, o_load_data,
           o_pop_vld, o_busy, o_done, o_loaded
  );

  modport slave (
    input  i_start, i_wgt_vld, i_wgt_data, i_pop_req,
    output o_wgt_rdy, o_load_vld, o_load_id, o_load_data,
           o_pop_vld, o_busy, o_done, o_loaded
  );

endinterface

// File: rtl/wgt_load_ctrl.sv
// Source end of one PE row's weight-load chain. Tags each accepted weight beat
// with its target PE ID (all PEs get slot 0 before slot 1), waits for the chain
// to drain, then reports completion and gates pop pulses into the array.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | no pass in progress; pops allowed once weights are resident
// ST_LOAD  | accepting beats and driving the load bus
// ST_DRAIN | last beat sent, waiting one hop per PE for the chain to settle
module wgt_load_ctrl #(
  parameter int NUM_PE     = 36,
  parameter int ID_WIDTH   = wgt_load_ctrl_pkg::DEF_ID_WIDTH,
  parameter int DATA_WIDTH = 8,
  parameter int WGT_DEPTH  = wgt_load_ctrl_pkg::WGT_DEPTH,
  parameter int DRAIN_CYC  = NUM_PE
) (
  input  logic           clk,
  input  logic           rst,
  wgt_load_ctrl_if.slave bus
);
  import wgt_load_ctrl_pkg::*;

  localparam int SLOT_W  = clog2_min1(WGT_DEPTH);
  localparam int DRAIN_W = clog2_min1(DRAIN_CYC + 1);

  localparam logic [ID_WIDTH-1:0] LAST_ID    = ID_WIDTH'(NUM_PE - 1);
  localparam logic [SLOT_W-1:0]   LAST_SLOT  = SLOT_W'(WGT_DEPTH - 1);
  localparam logic [DRAIN_W-1:0]  LAST_DRAIN = DRAIN_W'(DRAIN_CYC - 1);

  state_e                state_q, state_d;
  logic [ID_WIDTH-1:0]   id_cnt_q, id_cnt_d;
  logic [SLOT_W-1:0]     slot_cnt_q, slot_cnt_d;
  logic [DRAIN_W-1:0]    drain_cnt_q, drain_cnt_d;
  logic                  load_vld_q, load_vld_d;
  logic [ID_WIDTH-1:0]   load_id_q, load_id_d;
  logic [DATA_WIDTH-1:0] load_data_q, load_data_d;
  logic                  pop_vld_q, pop_vld_d;
  logic                  done_q, done_d;
  logic                  loaded_q, loaded_d;
  logic                  accept;

  assign accept = bus.i_wgt_vld && (state_q == ST_LOAD);

  // Next-state, counter and output-register logic; i_start beats a same-cycle pop.
  always_comb begin
    state_d     = state_q;
    id_cnt_d    = id_cnt_q;
    slot_cnt_d  = slot_cnt_q;
    drain_cnt_d = drain_cnt_q;
    load_vld_d  = 1'b0;
    load_id_d   = load_id_q;
    load_data_d = load_data_q;
    pop_vld_d   = 1'b0;
    done_d      = 1'b0;
    loaded_d    = loaded_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.i_start) begin
          state_d    = ST_LOAD;
          id_cnt_d   = '0;
          slot_cnt_d = '0;
          loaded_d   = 1'b0;
        end else if (bus.i_pop_req && loaded_q) begin
          pop_vld_d = 1'b1;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          load_vld_d  = 1'b1;
          load_id_d   = id_cnt_q;
          load_data_d = bus.i_wgt_data;
          if (id_cnt_q == LAST_ID) begin
            id_cnt_d   = '0;
            slot_cnt_d = slot_cnt_q + 1'b1;
            if (slot_cnt_q == LAST_SLOT) begin
              state_d     = ST_DRAIN;
              drain_cnt_d = '0;
            end
          end else begin
            id_cnt_d = id_cnt_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        drain_cnt_d = drain_cnt_q + 1'b1;
        if (drain_cnt_q == LAST_DRAIN) begin
          done_d   = 1'b1;
          loaded_d = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counters and registered outputs; reset discards any partial pass.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      id_cnt_q    <= '0;
      slot_cnt_q  <= '0;
      drain_cnt_q <= '0;
      load_vld_q  <= 1'b0;
      load_id_q   <= '0;
      load_data_q <= '0;
      pop_vld_q   <= 1'b0;
      done_q      <= 1'b0;
      loaded_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      id_cnt_q    <= id_cnt_d;
      slot_cnt_q  <= slot_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      load_vld_q  <= load_vld_d;
      load_id_q   <= load_id_d;
      load_data_q <= load_data_d;
      pop_vld_q   <= pop_vld_d;
      done_q      <= done_d;
      loaded_q    <= loaded_d;
    end
  end

  assign bus.o_wgt_rdy   = (state_q == ST_LOAD);
  assign bus.o_busy      = (state_q != ST_IDLE);
  assign bus.o_load_vld  = load_vld_q;
  assign bus.o_load_id   = load_id_q;
  assign bus.o_load_data = load_data_q;
  assign bus.o_pop_vld   = pop_vld_q;
  assign bus.o_done      = done_q;
  assign bus.o_loaded    = loaded_q;

endmodule

// File: tb/tb_wgt_load_ctrl.sv
// Bench for wgt_load_ctrl: directed scenarios plus a randomized phase, all
// outputs compared every cycle against a beat-count/timestamp model.
module tb_wgt_load_ctrl;

  localparam int NUM_PE = 4;
  localparam int ID_W   = 6;
  localparam int DW     = 8;
  localparam int DEPTH  = 2;
  localparam int DRAIN  = 4;
  localparam int TOTAL  = NUM_PE * DEPTH;

  logic clk = 1'b0;
  logic rst;

  wgt_load_ctrl_if #(.ID_WIDTH(ID_W), .DATA_WIDTH(DW)) bus ();

  wgt_load_ctrl #(
    .NUM_PE(NUM_PE), .ID_WIDTH(ID_W), .DATA_WIDTH(DW),
    .WGT_DEPTH(DEPTH), .DRAIN_CYC(DRAIN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: a pass is a count of accepted beats; done is a timestamp
  // DRAIN edges after the final beat's accepting edge.
  int   cyc;
  int   beats;
  int   done_cyc;
  bit   active;
  bit   loaded;
  logic m_load_vld, m_pop, m_done;
  logic [ID_W-1:0] m_id;
  logic [DW-1:0]   m_data;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc <= 0; beats <= 0; done_cyc <= -1; active <= 1'b0; loaded <= 1'b0;
      m_load_vld <= 1'b0; m_pop <= 1'b0; m_done <= 1'b0; m_id <= '0; m_data <= '0;
    end else begin
      cyc        <= cyc + 1;
      m_load_vld <= 1'b0;
      m_pop      <= 1'b0;
      m_done     <= 1'b0;
      if (!active) begin
        if (bus.i_start) begin
          active <= 1'b1; beats <= 0; loaded <= 1'b0;
        end else if (bus.i_pop_req && loaded) begin
          m_pop <= 1'b1;
        end
      end else if (beats < TOTAL) begin
        if (bus.i_wgt_vld) begin
          m_load_vld <= 1'b1;
          m_id       <= ID_W'(beats % NUM_PE);
          m_data     <= bus.i_wgt_data;
          beats      <= beats + 1;
          if (beats + 1 == TOTAL) done_cyc <= cyc + DRAIN;
        end
      end else if (cyc == done_cyc) begin
        active <= 1'b0; loaded <= 1'b1; m_done <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      check("rdy",       64'(bus.o_wgt_rdy),   64'(active && beats < TOTAL));
      check("load_vld",  64'(bus.o_load_vld),  64'(m_load_vld));
      check("load_id",   64'(bus.o_load_id),   64'(m_id));
      check("load_data", 64'(bus.o_load_data), 64'(m_data));
      check("pop_vld",   64'(bus.o_pop_vld),   64'(m_pop));
      check("busy",      64'(bus.o_busy),      64'(active));
      check("done",      64'(bus.o_done),      64'(m_done));
      check("loaded",    64'(bus.o_loaded),    64'(loaded));
    end
  end

  // Load-bus collector for the literal sequence checks.
  logic [ID_W+DW-1:0] lq[$];
  int tb_cyc = 0;
  int last_load_cyc = 0;
  int done_seen_cyc = 0;

  always @(negedge clk) begin
    tb_cyc <= tb_cyc + 1;
    if (rst === 1'b0 && bus.o_load_vld) begin
      lq.push_back({bus.o_load_id, bus.o_load_data});
      last_load_cyc <= tb_cyc;
    end
    if (rst === 1'b0 && bus.o_done) done_seen_cyc <= tb_cyc;
  end

  task automatic pulse_start();
    @(negedge clk) bus.i_start = 1'b1;
    @(negedge clk) bus.i_start = 1'b0;
  endtask

  task automatic stream(input int n, input bit toggle, input logic [DW-1:0] base,
                        input int start_at, input int rst_after);
    int sent = 0;
    int t = 0;
    while (sent < n && t < 400) begin
      @(negedge clk);
      if (sent == rst_after) begin
        bus.i_wgt_vld = 1'b0;
        bus.i_start   = 1'b0;
        #2 rst = 1'b1;
        #1 check("async_rst", 64'({bus.o_wgt_rdy, bus.o_load_vld, bus.o_load_id, bus.o_load_data,
                                   bus.o_pop_vld, bus.o_busy, bus.o_done, bus.o_loaded}), 64'(0));
        @(negedge clk) rst = 1'b0;
        return;
      end
      bus.i_wgt_vld  = toggle ? (t % 2 == 0) : 1'b1;
      bus.i_wgt_data = base + DW'(sent);
      bus.i_start    = (sent == start_at) && bus.i_wgt_vld;
      if (bus.i_wgt_vld && bus.o_wgt_rdy) sent++;
      t++;
    end
    check("stream_timeout", 64'(sent), 64'(n));
    @(negedge clk);
    bus.i_wgt_vld = 1'b0;
    bus.i_start   = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while (!bus.o_done && k < 100) begin
      @(negedge clk);
      k++;
    end
    check({name, "_done_timeout"}, 64'(k < 100), 64'(1));
    #1;
  endtask

  task automatic check_seq(input string name, input logic [DW-1:0] base);
    int ids[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    logic [DW-1:0] offs[8] = '{8'h0, 8'h1, 8'h2, 8'h3, 8'h4, 8'h5, 8'h6, 8'h7};
    check({name, "_len"}, 64'(lq.size()), 64'(8));
    for (int k = 0; k < 8 && k < lq.size(); k++)
      check({name, "_beat"}, 64'(lq[k]), 64'({ID_W'(ids[k]), base + offs[k]}));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_start = 1'b0; bus.i_wgt_vld = 1'b0; bus.i_wgt_data = '0; bus.i_pop_req = 1'b0;
    rst = 1'b0;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'({bus.o_wgt_rdy, bus.o_load_vld, bus.o_load_id, bus.o_load_data,
                                bus.o_pop_vld, bus.o_busy, bus.o_done, bus.o_loaded}), 64'(0));
    rst = 1'b0;

    // Pops before any load are ignored.
    bus.i_pop_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("pop_before_load", 64'(bus.o_pop_vld), 64'(0));
    end
    bus.i_pop_req = 1'b0;

    // Continuous 8-beat stream.
    lq.delete();
    pulse_start();
    stream(8, 1'b0, 8'h10, -1, -1);
    wait_done("t1");
    check_seq("t1", 8'h10);
    check("t1_done_offset", 64'(done_seen_cyc - last_load_cyc), 64'(4));
    check("t1_loaded", 64'(bus.o_loaded), 64'(1));

    // Three back-to-back pop requests, each answered one cycle later.
    @(negedge clk);
    bus.i_pop_req = 1'b1;
    check("pop_latency", 64'(bus.o_pop_vld), 64'(0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 2) bus.i_pop_req = 1'b0;
      check("pop_burst", 64'(bus.o_pop_vld), 64'(1));
    end
    @(negedge clk);
    check("pop_end", 64'(bus.o_pop_vld), 64'(0));

    // Gapped stream.
    lq.delete();
    pulse_start();
    stream(8, 1'b1, 8'h20, -1, -1);
    wait_done("t2");
    check_seq("t2", 8'h20);

    // i_start during beat 3 is ignored.
    lq.delete();
    pulse_start();
    stream(8, 1'b0, 8'h30, 3, -1);
    wait_done("t3");
    check_seq("t3", 8'h30);

    // Reset after beat 5, then a clean reload from ID 0.
    pulse_start();
    stream(8, 1'b0, 8'h40, -1, 5);
    check("t4_loaded_after_rst", 64'({bus.o_loaded, bus.o_busy}), 64'(0));
    lq.delete();
    pulse_start();
    stream(8, 1'b0, 8'h50, -1, -1);
    check("t4_loaded_in_drain", 64'(bus.o_loaded), 64'(0));
    wait_done("t4");
    check_seq("t4", 8'h50);

    // i_pop_req and i_start together: start wins.
    @(negedge clk);
    bus.i_start = 1'b1; bus.i_pop_req = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0; bus.i_pop_req = 1'b0;
    check("t6_no_pop", 64'(bus.o_pop_vld), 64'(0));
    check("t6_state", 64'({bus.o_loaded, bus.o_busy, bus.o_wgt_rdy}), 64'(3'b011));
    stream(8, 1'b0, 8'h60, -1, -1);
    wait_done("t6");

    // Randomized phase checked by the model.
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 299) == 0) rst = 1'b1;
      bus.i_start    = ($urandom_range(0, 19) == 0);
      bus.i_wgt_vld  = ($urandom_range(0, 3) != 0);
      bus.i_wgt_data = DW'($urandom);
      bus.i_pop_req  = $urandom_range(0, 1) == 1;
    end
    @(negedge clk);
    rst = 1'b0; bus.i_start = 1'b0; bus.i_wgt_vld = 1'b0; bus.i_pop_req = 1'b0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wgt_load_ctrl.md
Name: wgt_load_ctrl

Overview:
- Source end of the PE-array weight-load chain: drives the load bus (vld/id/data) into the first PE of each row.
- Accepts a valid/ready weight stream from the weight buffer and tags each beat with its target PE ID in slot-major order.
- Waits for the chain to drain, then signals completion and enables pop pulses for the array.
- One instance per PE row, between the weight buffer and PE column 0.

Parameters:
NUM_PE, 36, number of PEs on the chain (IDs 0..NUM_PE-1)
ID_WIDTH, 6, load-ID width; must satisfy 2**ID_WIDTH >= NUM_PE
DATA_WIDTH, 8, weight width
WGT_DEPTH, 2, weight slots per PE
DRAIN_CYC, NUM_PE, cycles to wait after the last beat before done (one hop per PE)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
i_start  in  1  one-cycle pulse, begin a load pass
i_wgt_vld  in  1  weight beat valid
i_wgt_data  in  DATA_WIDTH  weight beat
o_wgt_rdy  out  1  ready for a weight beat
o_load_vld  out  1  load-bus valid, to PE0 i_load_vld
o_load_id  out  ID_WIDTH  target PE ID
o_load_data  out  DATA_WIDTH  weight data
i_pop_req  in  1  request one pop step
o_pop_vld  out  1  pop pulse, to PE0 i_pop_vld
o_busy  out  1  high in LOAD or DRAIN
o_done  out  1  one-cycle pulse at end of DRAIN
o_loaded  out  1  weights resident; pops permitted

Behaviour:
- Single clock: clk. Reset is asynchronous and active-high on rst.
- Reset values: all outputs 0; state IDLE; id_cnt, slot_cnt, drain_cnt all 0.
- FSM states: IDLE, LOAD, DRAIN.
- IDLE -> LOAD on i_start. Clears id_cnt, slot_cnt and o_loaded.
- i_start is ignored in LOAD and DRAIN.
- o_wgt_rdy = (state==LOAD), combinational from the state register.
- Beat accept = i_wgt_vld && o_wgt_rdy.
- Each accepted beat registers one load-bus cycle: the cycle after accept, o_load_vld=1, o_load_id=id_cnt and o_load_data=i_wgt_data.
- On cycles with no accept, o_load_vld=0; id and data hold their last values.
- Load-bus latency is 1 cycle. The load bus has no backpressure.
- Ordering: id_cnt increments per beat.
  - At NUM_PE-1, id_cnt wraps to 0 and slot_cnt increments.
  - Every PE therefore receives slot 0 before slot 1.
- Last beat (id_cnt==NUM_PE-1 and slot_cnt==WGT_DEPTH-1): on accept, LOAD -> DRAIN and drain_cnt=0. o_wgt_rdy is 0 from the next cycle on.
- DRAIN: drain_cnt increments every cycle. At drain_cnt==DRAIN_CYC-1:
  - o_done pulses for 1 cycle (registered);
  - o_loaded is set;
  - the next state is IDLE.
- o_busy = (state!=IDLE).
- Pop: in IDLE with o_loaded=1, each i_pop_req produces o_pop_vld=1 exactly one cycle later.
- Pops are back-to-back capable. i_pop_req is ignored when o_loaded=0 or the FSM is busy.
- i_pop_req and i_start in the same IDLE cycle: i_start wins, no pop is issued, o_loaded clears.
- Reset mid-LOAD or mid-DRAIN: everything returns to reset values immediately. Partial loads are discarded; a new i_start reloads from ID 0, slot 0.
- Width rules: id_cnt is ID_WIDTH bits; slot_cnt is $clog2(WGT_DEPTH) bits, minimum 1; drain_cnt is $clog2(DRAIN_CYC+1) bits.

Decomposition:
- Shared package holds:
  - state enum typedef (IDLE/LOAD/DRAIN);
  - constant WGT_DEPTH=2, shared with the PE slot count;
  - default ID_WIDTH;
  - function clog2_min1.
- No sub-module. The FSM, counters and output registers are all contained in one module.

Test Plan (NUM_PE=4, WGT_DEPTH=2, DRAIN_CYC=4):
- Continuous stream 8 beats 0x10..0x17 after i_start -> load bus shows (id,data) (0,10)(1,11)(2,12)(3,13)(0,14)(1,15)(2,16)(3,17) on 8 consecutive cycles, each 1 cycle after accept. o_wgt_rdy drops after the 8th accept. o_done pulses 4 cycles after the last o_load_vld cycle; o_loaded=1.
- i_wgt_vld toggled 1/0 each cycle -> o_load_vld has gaps matching the input gaps, ID sequence unchanged, o_busy=1 throughout.
- i_start pulsed during LOAD beat 3 -> ignored; the sequence continues at id=3, slot 0.
- rst asserted after beat 5 -> all outputs 0 asynchronously. Then i_start plus 8 beats -> the sequence restarts at (0,slot0); o_loaded=0 until the new o_done.
- After o_loaded, i_pop_req high for 3 cycles -> o_pop_vld high for 3 cycles, delayed 1 cycle. i_pop_req before any load -> o_pop_vld stays 0.
- i_pop_req and i_start in the same cycle -> no o_pop_vld, o_loaded=0, state LOAD.
